// File: rtl/fetch_unit.sv
// Instruction fetch: drives the memory read port and buffers fetched words with their PCs.
// Latency: an issue in cycle t is pushed at the end of t+1, so instr_valid rises in t+2.
// Backpressure: a credit check (count + pending - pop < DEPTH) throttles issue; a store stalls issue.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] mem_read_address,
  output logic [2:0]  mem_funct3,
  input  logic [31:0] mem_read_data,
  input  logic        mem_write_mem,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

  logic [31:0]   r_pc;
  logic [31:0]   r_pend_pc;
  logic          r_pending;
  logic [31:0]   r_data_q [DEPTH];
  logic [31:0]   r_pc_q   [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  logic          w_pop;
  logic          w_push;
  logic          w_issue;
  logic [31:0]   w_fetch_addr;
  logic [CW:0]   w_credit;

  // Fetch address selection, credit check and FIFO handshake terms.
  always_comb begin
    w_pop        = (r_count != '0) & instr_ready;
    w_fetch_addr = redirect_valid ? (redirect_pc & 32'hFFFF_FFFC) : r_pc;
    w_credit     = {1'b0, r_count} + (CW + 1)'(r_pending) - (CW + 1)'(w_pop);
    w_issue      = !reset & !mem_write_mem & (w_credit < (CW + 1)'(DEPTH));
    // A response landing in a redirect cycle belongs to the abandoned path.
    w_push       = r_pending & !redirect_valid;
  end

  assign mem_read_address = w_fetch_addr;
  assign mem_funct3       = 3'b010;
  assign instr_valid      = (r_count != '0);
  assign instr            = r_data_q[r_rd_ptr];
  assign instr_pc         = r_pc_q[r_rd_ptr];

  // PC advance and outstanding-read tracking; a stalled cycle still latches a redirect target.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc      <= RESET_PC;
      r_pending <= 1'b0;
      r_pend_pc <= 32'h0;
    end else if (w_issue) begin
      r_pc      <= w_fetch_addr + 32'd4;
      r_pending <= 1'b1;
      r_pend_pc <= w_fetch_addr;
    end else begin
      r_pc      <= w_fetch_addr;
      r_pending <= 1'b0;
    end
  end

  // Circular instruction buffer; a redirect empties it after the current head is handed over.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_data_q[i] <= 32'h0;
        r_pc_q[i]   <= 32'h0;
      end
    end else if (redirect_valid) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_data_q[r_wr_ptr] <= mem_read_data;
        r_pc_q[r_wr_ptr]   <= r_pend_pc;
        r_wr_ptr           <= (r_wr_ptr == LAST_PTR) ? '0 : r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= (r_rd_ptr == LAST_PTR) ? '0 : r_rd_ptr + PW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a one-cycle read memory model and an in-order scoreboard.
// Latency: expected instructions are queued up front; the monitor pops one per accepted handshake.
// Backpressure: instr_ready is dropped in chosen cycles; stores, redirects and reset are scheduled per cycle.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] mem_read_address;
  logic [2:0]  mem_funct3;
  logic [31:0] mem_read_data = 32'h0;
  logic        mem_write_mem;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;

  int n_cmp = 0;
  int n_bad = 0;
  logic [63:0] exp_q [$];

  fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
    .clk              (clk),
    .reset            (reset),
    .mem_read_address (mem_read_address),
    .mem_funct3       (mem_funct3),
    .mem_read_data    (mem_read_data),
    .mem_write_mem    (mem_write_mem),
    .redirect_valid   (redirect_valid),
    .redirect_pc      (redirect_pc),
    .instr_valid      (instr_valid),
    .instr            (instr),
    .instr_pc         (instr_pc),
    .instr_ready      (instr_ready)
  );

  always #5 clk = ~clk;

  // Memory image: word at byte address a is "addi xN, x0, N" with N = a/4.
  function automatic logic [31:0] word(input logic [31:0] a);
    logic [31:0] n;
    n = a >> 2;
    return (n << 20) | ((n & 32'h1F) << 7) | 32'h13;
  endfunction

  // Read port returns the addressed word next cycle and holds it during a store.
  always @(posedge clk) begin
    if (!mem_write_mem) mem_read_data <= word(mem_read_address);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic expect_pc(input logic [31:0] pc);
    exp_q.push_back({pc, word(pc)});
  endtask

  // Monitor: every accepted head is compared against the oldest expectation.
  always @(negedge clk) begin
    if (reset === 1'b0 && instr_valid === 1'b1 && instr_ready === 1'b1) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_instr: got pc %h instr %h expected none", instr_pc, instr);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        if ({instr_pc, instr} !== e) begin
          n_bad++;
          $display("FAIL instr_stream: got pc %h instr %h expected pc %h instr %h",
                   instr_pc, instr, e[63:32], e[31:0]);
        end
      end
    end
  end

  initial begin
    reset          = 1'b1;
    instr_ready    = 1'b0;
    mem_write_mem  = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("reset_valid", {31'h0, instr_valid}, 32'h0);
    chk("reset_instr", instr, 32'h0);
    chk("reset_instr_pc", instr_pc, 32'h0);
    chk("reset_addr", mem_read_address, 32'h0);
    @(posedge clk);
    #1;

    for (int c = 0; c < 42; c++) begin
      // Per-cycle stimulus.
      reset          = (c == 30);
      instr_ready    = !((c >= 5 && c <= 10) || c == 20 || c == 30 || c >= 37);
      mem_write_mem  = (c == 14 || c == 15);
      redirect_valid = (c == 20 || c == 25);
      redirect_pc    = (c == 20) ? 32'h0000_0103 : (c == 25) ? 32'hFFFF_FFFC : 32'h0;

      // Expected delivered stream, queued as each phase starts.
      if (c == 0)  for (int k = 0; k < 10; k++) expect_pc(32'(k * 4));
      if (c == 20) begin expect_pc(32'h100); expect_pc(32'h104); expect_pc(32'h108); end
      if (c == 25) begin expect_pc(32'hFFFF_FFFC); expect_pc(32'h0); expect_pc(32'h4); end
      if (c == 30) for (int k = 0; k < 4; k++) expect_pc(32'(k * 4));

      @(negedge clk);
      case (c)
        0: begin
          chk("stream_addr_c0", mem_read_address, 32'h0);
          chk("funct3", {29'h0, mem_funct3}, 32'h2);
          chk("stream_valid_c0", {31'h0, instr_valid}, 32'h0);
        end
        1: begin
          chk("stream_addr_c1", mem_read_address, 32'h4);
          chk("stream_valid_c1", {31'h0, instr_valid}, 32'h0);
        end
        2: begin
          chk("stream_addr_c2", mem_read_address, 32'h8);
          chk("stream_valid_c2", {31'h0, instr_valid}, 32'h1);
        end
        5, 6, 7, 8, 9, 10: begin
          chk("bp_addr_frozen", mem_read_address, 32'h14);
          chk("bp_valid_held", {31'h0, instr_valid}, 32'h1);
        end
        11: chk("bp_resume_addr", mem_read_address, 32'h14);
        14, 15, 16: chk("stall_addr_held", mem_read_address, 32'h20);
        17: begin
          chk("stall_next_addr", mem_read_address, 32'h24);
          chk("stall_valid_gap", {31'h0, instr_valid}, 32'h0);
        end
        20: chk("redirect_addr", mem_read_address, 32'h100);
        21: begin
          chk("redirect_flushed", {31'h0, instr_valid}, 32'h0);
          chk("redirect_fetch", mem_read_address, 32'h100);
        end
        23: chk("redirect_first_pc", instr_pc, 32'h100);
        25: chk("wrap_redirect_addr", mem_read_address, 32'hFFFF_FFFC);
        26: chk("wrap_addr", mem_read_address, 32'h0);
        27: chk("wrap_addr_next", mem_read_address, 32'h4);
        31: begin
          chk("rst_mid_valid", {31'h0, instr_valid}, 32'h0);
          chk("rst_mid_addr", mem_read_address, 32'h0);
        end
        32: chk("rst_mid_addr_next", mem_read_address, 32'h4);
        33: chk("rst_mid_first_pc", instr_pc, 32'h0);
        default: ;
      endcase
      @(posedge clk);
      #1;
    end

    chk("stream_drained", 32'(exp_q.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
